// File: rtl/demux1to8_deser_cgrundey.sv
// demux1to8_deser_cgrundey
//   Receive side of the 8-to-1 serial mux link. Each enabled bit is steered by
//   an internal select counter into a hold register. A completed word appears
//   on the registered demux_out bus together with a one-cycle data_valid
//   strobe.
//
//   Optional feature macro: DEMUX_PARITY_EN
//     When defined, each frame carries one extra even-parity bit after the
//     data. The result of the parity check is reported on parity_err.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for enable&sync to start a frame, select = 0
//   CAPTURE  | collecting bits 1..WIDTH-1, select = next bit position
//   PARITY   | (DEMUX_PARITY_EN only) waiting for the trailing parity bit
module demux1to8_deser_cgrundey #(
  parameter int  WIDTH     = 8,
  parameter bit  MSB_FIRST = 1'b0,
  localparam int SEL_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sync,
  input  logic             demux_in,
  output logic [WIDTH-1:0] demux_out,
  output logic             data_valid,
  output logic [SEL_W-1:0] select,
  output logic             busy,
  output logic             frame_err
`ifdef DEMUX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
`ifdef DEMUX_PARITY_EN
  localparam logic [1:0] ST_PARITY  = 2'd2;
`endif

  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;
  logic [WIDTH-1:0] word_ins;
  logic [WIDTH-1:0] word_start;
  logic [WIDTH-1:0] out_d;
  logic [SEL_W-1:0] sel_d;
  logic             valid_d;
  logic             err_d;
`ifdef DEMUX_PARITY_EN
  logic             par_d;
`endif

  // Map a frame position to its bit index in the output word.
  function automatic logic [SEL_W-1:0] bit_pos(input logic [SEL_W-1:0] p);
    return MSB_FIRST ? (SEL_LAST - p) : p;
  endfunction

  // Candidate words: the current bit inserted at select, or a fresh frame
  // that starts with the current bit at position 0.
  always_comb begin
    word_ins                   = word_q;
    word_ins[bit_pos(select)]  = demux_in;
    word_start                 = '0;
    word_start[bit_pos('0)]    = demux_in;
  end

  // Next-state and datapath decisions.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = select;
    out_d   = demux_out;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef DEMUX_PARITY_EN
    par_d   = parity_err;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable && sync) begin
          word_d  = word_start;
          sel_d   = SEL_ONE;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (enable) begin
          if (sync) begin
            // A new sync mid-frame abandons the partial word; the current bit
            // becomes bit 0 of the next frame.
            err_d  = 1'b1;
            word_d = word_start;
            sel_d  = SEL_ONE;
          end else if (select == SEL_LAST) begin
            word_d = word_ins;
            sel_d  = '0;
`ifdef DEMUX_PARITY_EN
            state_d = ST_PARITY;
`else
            out_d   = word_ins;
            valid_d = 1'b1;
            state_d = ST_IDLE;
`endif
          end else begin
            word_d = word_ins;
            sel_d  = select + SEL_ONE;
          end
        end
      end
`ifdef DEMUX_PARITY_EN
      ST_PARITY: begin
        if (enable) begin
          if (sync) begin
            err_d   = 1'b1;
            word_d  = word_start;
            sel_d   = SEL_ONE;
            state_d = ST_CAPTURE;
          end else begin
            // Even parity: data bits plus parity bit must XOR to zero.
            out_d   = word_q;
            valid_d = 1'b1;
            par_d   = ^{word_q, demux_in};
            state_d = ST_IDLE;
          end
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // State, hold register, select counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      select     <= '0;
      demux_out  <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef DEMUX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      select     <= sel_d;
      demux_out  <= out_d;
      data_valid <= valid_d;
      frame_err  <= err_d;
`ifdef DEMUX_PARITY_EN
      parity_err <= par_d;
`endif
    end
  end

  // busy comes straight from the state register, so reset clears it at once.
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_demux1to8_deser_cgrundey.sv
// tb_demux1to8_deser_cgrundey
//   Directed stimulus for the 1-to-8 deserializer (LSB-first, WIDTH=8).
//   Built with DEMUX_PARITY_EN, each frame also carries an even-parity bit.
module tb_demux1to8_deser_cgrundey;

`ifdef DEMUX_PARITY_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       sync;
  logic       demux_in;
  logic [7:0] demux_out;
  logic       data_valid;
  logic [2:0] select;
  logic       busy;
  logic       frame_err;
`ifdef DEMUX_PARITY_EN
  logic       parity_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  demux1to8_deser_cgrundey #(
    .WIDTH     (8),
    .MSB_FIRST (1'b0)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .sync       (sync),
    .demux_in   (demux_in),
    .demux_out  (demux_out),
    .data_valid (data_valid),
    .select     (select),
    .busy       (busy),
    .frame_err  (frame_err)
`ifdef DEMUX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Bit i of a frame; index 8 is the even-parity bit.
  function automatic logic fbit(input logic [7:0] w, input int i);
    if (i < 8) return w[i];
    return ^w;
  endfunction

  // Drive one bit, then settle 1 ns past the sampling edge.
  task automatic send_bit(input logic en, input logic sy, input logic b);
    enable   = en;
    sync     = sy;
    demux_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] w);
    for (int i = 0; i < FRAME_LEN; i++) send_bit(1'b1, i == 0, fbit(w, i));
    enable = 1'b0;
    sync   = 1'b0;
  endtask

  initial begin
    int dv_early;
    rst_n    = 1'b0;
    enable   = 1'b0;
    sync     = 1'b0;
    demux_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out",    demux_out,  8'h00);
    check_val("rst_select", select,     3'd0);
    check_val("rst_busy",   busy,       1'b0);
    check_val("rst_valid",  data_valid, 1'b0);
    check_val("rst_ferr",   frame_err,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle noise: sync without enable, and data without sync, are ignored.
    send_bit(1'b0, 1'b1, 1'b1);
    check_val("idle_nosync_busy", busy, 1'b0);
    send_bit(1'b1, 1'b0, 1'b1);
    check_val("idle_nodata_busy", busy, 1'b0);
    check_val("idle_nodata_ferr", frame_err, 1'b0);

    // Basic frame 8'hA5.
    send_bit(1'b1, 1'b1, fbit(8'hA5, 0));
    check_val("a5_sel_after_b0", select, 3'd1);
    check_val("a5_busy",         busy,   1'b1);
    for (int i = 1; i < FRAME_LEN - 1; i++) send_bit(1'b1, 1'b0, fbit(8'hA5, i));
    check_val("a5_valid_early", data_valid, 1'b0);
    send_bit(1'b1, 1'b0, fbit(8'hA5, FRAME_LEN - 1));
    check_val("a5_valid", data_valid, 1'b1);
    check_val("a5_out",   demux_out,  8'hA5);
    check_val("a5_sel0",  select,     3'd0);
    check_val("a5_idle",  busy,       1'b0);
`ifdef DEMUX_PARITY_EN
    check_val("a5_perr", parity_err, 1'b0);
`endif
    send_bit(1'b0, 1'b0, 1'b0);
    check_val("a5_valid_pulse", data_valid, 1'b0);
    check_val("a5_out_hold",    demux_out,  8'hA5);

    // Stall 8'h3C: bits 0..4, three disabled cycles with sync/data noise.
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0, fbit(8'h3C, i));
    for (int k = 0; k < 3; k++) begin
      send_bit(1'b0, 1'b1, k[0]);
      check_val("stall_sel",  select,    3'd5);
      check_val("stall_ferr", frame_err, 1'b0);
    end
    for (int i = 5; i < FRAME_LEN; i++) send_bit(1'b1, 1'b0, fbit(8'h3C, i));
    check_val("3c_valid", data_valid, 1'b1);
    check_val("3c_out",   demux_out,  8'h3C);

    // Abort: five bits of 8'h55, then sync starts a full 8'hFF frame.
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0, fbit(8'h55, i));
    send_bit(1'b1, 1'b1, fbit(8'hFF, 0));
    check_val("abort_ferr",  frame_err,  1'b1);
    check_val("abort_valid", data_valid, 1'b0);
    check_val("abort_out",   demux_out,  8'h3C);
    check_val("abort_sel",   select,     3'd1);
    send_bit(1'b1, 1'b0, fbit(8'hFF, 1));
    check_val("abort_ferr_pulse", frame_err, 1'b0);
    for (int i = 2; i < FRAME_LEN; i++) send_bit(1'b1, 1'b0, fbit(8'hFF, i));
    check_val("ff_valid", data_valid, 1'b1);
    check_val("ff_out",   demux_out,  8'hFF);
    check_val("ff_ferr",  frame_err,  1'b0);

    // Back-to-back 8'h01 then 8'h80 with no gap cycle.
    for (int i = 0; i < FRAME_LEN; i++) send_bit(1'b1, i == 0, fbit(8'h01, i));
    check_val("b2b_01_valid", data_valid, 1'b1);
    check_val("b2b_01_out",   demux_out,  8'h01);
    dv_early = 0;
    for (int i = 0; i < FRAME_LEN - 1; i++) begin
      send_bit(1'b1, i == 0, fbit(8'h80, i));
      if (data_valid) dv_early++;
    end
    check_val("b2b_no_early_valid", dv_early, 0);
    send_bit(1'b1, 1'b0, fbit(8'h80, FRAME_LEN - 1));
    check_val("b2b_80_valid", data_valid, 1'b1);
    check_val("b2b_80_out",   demux_out,  8'h80);
    enable = 1'b0;
    sync   = 1'b0;

`ifdef DEMUX_PARITY_EN
    // 8'h07 has three ones: parity bit 1 is correct, 0 is an error.
    for (int i = 0; i < 8; i++) send_bit(1'b1, i == 0, fbit(8'h07, i));
    check_val("par_wait_valid", data_valid, 1'b0);
    check_val("par_wait_busy",  busy,       1'b1);
    send_bit(1'b1, 1'b0, 1'b1);
    check_val("par_ok_valid", data_valid, 1'b1);
    check_val("par_ok_out",   demux_out,  8'h07);
    check_val("par_ok_perr",  parity_err, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b1, i == 0, fbit(8'h07, i));
    send_bit(1'b1, 1'b0, 1'b0);
    check_val("par_bad_valid", data_valid, 1'b1);
    check_val("par_bad_perr",  parity_err, 1'b1);
    enable = 1'b0;
`endif

    // Reset mid-frame clears everything without a clock edge.
    for (int i = 0; i < 3; i++) send_bit(1'b1, i == 0, fbit(8'h0F, i));
    check_val("mid_busy_before", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_out",   demux_out,  8'h00);
    check_val("mid_rst_sel",   select,     3'd0);
    check_val("mid_rst_busy",  busy,       1'b0);
    check_val("mid_rst_valid", data_valid, 1'b0);
    check_val("mid_rst_ferr",  frame_err,  1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_bit(1'b1, 1'b0, 1'b1);
    check_val("post_rst_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
